vector_operand_buffer: RTL and testbench
========================================

# vector_operand_buffer

Single-bank, E-lane operand buffer used by the vector add/sub datapath. It serves the compute-side RAM request bundle (raddr, wren, waddr, wdata) with a fixed read latency. It also provides a host-side load stream (fill) and drain stream (unload), both with valid/ready handshakes. The vector controller instantiates one per operand; host DMA fills it before a vector operation and drains it afterwards.

## Interface

- E, 8: lanes per word (power of two).
- FSIZE, 64: bits per lane.
- WIDTH, 10: word address width (logN-logE); depth 2^WIDTH words.
- LOGE_W, 3: width of diff_logN.
- READ_LATENCY, 2: cycles from raddr to rdata on the compute port (≥1).

Ports:

- clk  in  1  clock.
- rstn  in  1  reset. Synchronous, active-low.
- diff_logN  in  LOGE_W  length shrink. Transfer length is 2^(WIDTH-diff_logN) words; sampled on ld_start/st_start.
- raddr  in  WIDTH  compute read address; sampled every cycle.
- rdata  out  E*FSIZE  compute read data; lane i at [i*FSIZE +: FSIZE].
- wren  in  1  compute write enable.
- waddr  in  WIDTH  compute write address.
- wdata  in  E*FSIZE  compute write data.
- ld_start  in  1  begin fill at word 0.
- ld_valid  in  1  host load word valid.
- ld_ready  out  1  buffer accepts load word.
- ld_data  in  E*FSIZE  host load word.
- st_start  in  1  begin drain at word 0.
- st_valid  out  1  drain word valid.
- st_ready  in  1  host accepts drain word.
- st_data  out  E*FSIZE  drain word.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse when a fill or drain completes.
- err  out  1  sticky; set on a compute write during LOAD/DRAIN, or on ld_start/st_start while busy. Cleared only by reset.

## Operation

- States: IDLE, LOAD, DRAIN.
- IDLE:
  - The compute port is fully active.
  - A write with wren=1 stores wdata at waddr.
  - The read of raddr returns the RAM content, with write-first forwarding: if the write and read addresses match in the same cycle, rdata carries the new wdata.
- IDLE→LOAD on ld_start. Latch len = 2^(WIDTH-diff_logN) and set the word counter to 0.
- IDLE→DRAIN on st_start, with the same latching.
- ld_start and st_start asserted together in IDLE: LOAD wins, the drain request is dropped, and err is set.
- LOAD:
  - ld_ready=1.
  - Each ld_valid&&ld_ready handshake writes ld_data at the counter address and increments the counter.
  - The handshake that writes word len-1 returns the block to IDLE and pulses done on the next cycle.
- DRAIN:
  - Reads are issued internally from the counter while the in-flight count plus the output FIFO occupancy is below READ_LATENCY+1.
  - Read data lands in a (READ_LATENCY+1)-deep output FIFO, so st_ready may drop at any time without loss or duplication.
  - st_valid = FIFO not empty; st_data = FIFO head.
  - After len words have been handshaked, return to IDLE and pulse done.
- Compute port during LOAD/DRAIN:
  - Writes are ignored and set err.
  - rdata is undefined but must not disturb RAM contents.
- busy is not asserted in IDLE.
- Address arithmetic is WIDTH-bit unsigned. The counter never exceeds len-1, so no wrap occurs within a transfer.
- diff_logN > WIDTH is illegal; behaviour is unspecified apart from err.

## Timing

- Compute read: rdata for the raddr presented in cycle t is valid in cycle t+READ_LATENCY.
- Compute write: visible to a read issued in cycle t+1, and to a same-cycle read through forwarding.
- Load: one word per cycle at full throughput. The first word may be handshaked in the cycle after ld_start.
- Drain: first st_valid no earlier than cycle (st_start)+1+READ_LATENCY. With st_ready held high, one word per cycle sustained.
- done is a single-cycle pulse one cycle after the last handshake. busy drops in the same cycle done rises.
- Reset (synchronous, rstn=0 at a clock edge):
  - State returns to IDLE; counters and FIFO are cleared.
  - busy=0, done=0, err=0, ld_ready=0, st_valid=0, rdata=0.
  - RAM contents are not cleared.
  - Reset in the middle of a LOAD/DRAIN aborts the transfer with no done pulse.

## Test plan

- Fill, compute readback: diff_logN=0, load words w[k] = lane i value k*E+i for k = 0..1023. Expect done once, 1024 handshakes, busy high throughout. Compute reads at 0, 511, 1023 return the matching w at +2 cycles.
- Drain with backpressure: preload the pattern, st_start, toggle st_ready with a random 50% duty. Expect exactly 1024 st_data words in order, no gaps in sequence, no duplicates; done after the last word.
- Short length: diff_logN=3. Load stops after 128 handshakes, done pulses, ld_ready=0 afterwards. Words 128..1023 keep their old values.
- Same-cycle forward: wren=1, waddr=raddr=5, wdata=X. Expect rdata=X two cycles later. A read of 5 in the next cycle also returns X.
- Protocol errors: compute wren during LOAD, then ld_start while busy. Expect err=1 and sticky, RAM at waddr unchanged, the transfer itself completing normally.
- Reset mid-drain: assert rstn=0 after 10 drained words. The next cycle shows busy=0, st_valid=0, err=0, and no done pulse. A subsequent drain restarts from word 0.

Source files
------------

// File: rtl/vector_operand_buffer_if.sv
`default_nettype none
// ============================================================================
// vector_operand_buffer_if : compute RAM port, host fill/drain streams, status
// Revision: 1.0
// ============================================================================
interface vector_operand_buffer_if #(
    parameter int E      = 8,
    parameter int FSIZE  = 64,
    parameter int WIDTH  = 10,
    parameter int LOGE_W = 3
);
    localparam int DW = E * FSIZE;

    logic [LOGE_W-1:0] diff_logN;
    logic [WIDTH-1:0]  raddr;
    logic [DW-1:0]     rdata;
    logic              wren;
    logic [WIDTH-1:0]  waddr;
    logic [DW-1:0]     wdata;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [DW-1:0]     ld_data;
    logic              st_start;
    logic              st_valid;
    logic              st_ready;
    logic [DW-1:0]     st_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output diff_logN, raddr, wren, waddr, wdata,
        output ld_start, ld_valid, ld_data, st_start, st_ready,
        input  rdata, ld_ready, st_valid, st_data, busy, done, err
    );

    modport slave (
        input  diff_logN, raddr, wren, waddr, wdata,
        input  ld_start, ld_valid, ld_data, st_start, st_ready,
        output rdata, ld_ready, st_valid, st_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/vector_operand_buffer.sv
`default_nettype none
// ============================================================================
// vector_operand_buffer : E-lane operand RAM with compute port and host fill/drain
// Revision: 1.0
// ============================================================================
module vector_operand_buffer #(
    parameter int E            = 8,
    parameter int FSIZE        = 64,
    parameter int WIDTH        = 10,
    parameter int LOGE_W       = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    vector_operand_buffer_if.slave bus
);
    localparam int DW    = E * FSIZE;
    localparam int DEPTH = 1 << WIDTH;
    localparam int FD    = READ_LATENCY + 1;
    localparam int PW    = $clog2(FD);
    localparam int CW    = $clog2(FD + 1);
    localparam int OW    = CW + 1;
    localparam logic [WIDTH:0] LEN_MAX  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] ONE_W    = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0]  PTR_LAST = PW'(FD - 1);
    localparam logic [OW-1:0]  FD_OW    = OW'(FD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [WIDTH:0]                    len_q, len_d;
    logic [WIDTH:0]                    cnt_q, cnt_d;
    logic [WIDTH:0]                    hs_q, hs_d;
    logic                              done_q, done_d;
    logic                              err_q, err_d;
    logic [CW-1:0]                     infl_q, infl_d;
    logic [CW-1:0]                     occ_q, occ_d;
    logic [PW-1:0]                     wp_q, wp_d;
    logic [PW-1:0]                     rp_q, rp_d;
    logic [READ_LATENCY-1:0]           rv_q, rv_d;
    logic [READ_LATENCY-1:0][DW-1:0]   rd_pipe_q;
    logic [DW-1:0]                     ram  [DEPTH];
    logic [DW-1:0]                     fifo [FD];

    logic [LOGE_W-1:0] diff;
    logic [WIDTH:0]    len_calc;
    logic              bad_len, ld_fire, pop, land, issue, fwd, ram_we;
    logic [WIDTH-1:0]  ram_wa, ram_ra;
    logic [DW-1:0]     ram_wd;
    logic [OW-1:0]     pending;

    always_comb begin
        diff     = bus.diff_logN;
        bad_len  = 32'(diff) > WIDTH;
        len_calc = bad_len ? ONE_W : (LEN_MAX >> diff);
        ld_fire  = (state_q == S_LOAD) && bus.ld_valid;
        pop      = (occ_q != '0) && bus.st_ready;
        land     = rv_q[READ_LATENCY-1];
        // The word leaving the FIFO this cycle frees its slot, so a steady stream never stalls
        pending  = OW'(infl_q) + OW'(occ_q) - OW'(pop);
        issue    = (state_q == S_DRAIN) && (cnt_q != len_q) && (pending < FD_OW);
        fwd      = (state_q == S_IDLE) && bus.wren && (bus.waddr == bus.raddr);
        ram_we   = ld_fire || ((state_q == S_IDLE) && bus.wren);
        ram_wa   = ld_fire ? cnt_q[WIDTH-1:0] : bus.waddr;
        ram_wd   = ld_fire ? bus.ld_data : bus.wdata;
        ram_ra   = (state_q == S_DRAIN) ? cnt_q[WIDTH-1:0] : bus.raddr;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hs_d    = hs_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_start || bus.st_start) begin
                    len_d   = len_calc;
                    cnt_d   = '0;
                    hs_d    = '0;
                    state_d = bus.ld_start ? S_LOAD : S_DRAIN;
                    if ((bus.ld_start && bus.st_start) || bad_len) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (ld_fire) begin
                    cnt_d = cnt_q + ONE_W;
                    if (cnt_q == len_q - ONE_W) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (issue) begin
                    cnt_d = cnt_q + ONE_W;
                end
                if (pop) begin
                    hs_d = hs_q + ONE_W;
                    if (hs_q == len_q - ONE_W) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && (bus.wren || bus.ld_start || bus.st_start)) begin
            err_d = 1'b1;
        end
    end

    // Drain read tracking: rv marks pipeline stages carrying a drain read
    always_comb begin
        rv_d   = READ_LATENCY'({rv_q, issue});
        infl_d = infl_q + CW'(issue) - CW'(land);
        occ_d  = occ_q + CW'(land) - CW'(pop);
        wp_d   = land ? ((wp_q == PTR_LAST) ? '0 : wp_q + PW'(1)) : wp_q;
        rp_d   = pop  ? ((rp_q == PTR_LAST) ? '0 : rp_q + PW'(1)) : rp_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            hs_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            infl_q  <= '0;
            occ_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            rv_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hs_q    <= hs_d;
            done_q  <= done_d;
            err_q   <= err_d;
            infl_q  <= infl_d;
            occ_q   <= occ_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rv_q    <= rv_d;
        end
    end

    // Storage arrays are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_wa] <= ram_wd;
        end
        if (land) begin
            fifo[wp_q] <= rd_pipe_q[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q[0] <= fwd ? bus.wdata : ram[ram_ra];
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_pipe_q[k] <= rd_pipe_q[k-1];
            end
        end
    end

    assign bus.rdata    = rd_pipe_q[READ_LATENCY-1];
    assign bus.ld_ready = (state_q == S_LOAD);
    assign bus.st_valid = (occ_q != '0);
    assign bus.st_data  = fifo[rp_q];
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_vector_operand_buffer.sv
`default_nettype none
// ============================================================================
// tb_vector_operand_buffer : randomized scoreboard bench with a memory-array model
// Revision: 1.0
// ============================================================================
module tb_vector_operand_buffer;
    localparam int E      = 8;
    localparam int FSIZE  = 64;
    localparam int WIDTH  = 10;
    localparam int LOGE_W = 3;
    localparam int RL     = 2;
    localparam int DW     = E * FSIZE;
    localparam int DEPTH  = 1 << WIDTH;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    vector_operand_buffer_if #(.E(E), .FSIZE(FSIZE), .WIDTH(WIDTH), .LOGE_W(LOGE_W)) bus ();

    vector_operand_buffer #(
        .E(E), .FSIZE(FSIZE), .WIDTH(WIDTH), .LOGE_W(LOGE_W), .READ_LATENCY(RL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    logic [DW-1:0] st_q[$];
    logic [DW-1:0] model [DEPTH];
    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] w;
        for (int i = 0; i < E; i++) w[i*FSIZE +: FSIZE] = FSIZE'(k * E + i);
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < E; i++) w[i*FSIZE +: FSIZE] = FSIZE'({$urandom, $urandom});
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int due, input logic [DW-1:0] data);
        rd_exp_t e;
        e.due  = due;
        e.data = data;
        rd_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.diff_logN = '0;
        bus.raddr     = '0;
        bus.wren      = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.ld_start  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.st_start  = 1'b0;
        bus.st_ready  = 1'b0;
    endtask

    task automatic compute_read(input int addr);
        bus.wren  = 1'b0;
        bus.raddr = WIDTH'(addr);
        push_rd(cyc + RL, model[addr]);
        tick();
    endtask

    task automatic do_load(input int diff, input bit gaps, input bit inject);
        int len = DEPTH >> diff;
        int k = 0, guard = 0, d0 = done_cnt;
        bit busy_ok = 1'b1, inj_w = 1'b0, inj_s = 1'b0;
        logic [DW-1:0] w;
        bus.diff_logN = LOGE_W'(diff);
        bus.ld_start  = 1'b1;
        tick();
        bus.ld_start  = 1'b0;
        while (k < len && guard < 4 * len + 50) begin
            w = gaps ? rand_word() : pat(k);
            bus.ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.ld_data  = w;
            bus.wren     = 1'b0;
            bus.ld_start = 1'b0;
            if (inject && k == 5 && !inj_w) begin
                bus.wren  = 1'b1;
                bus.waddr = WIDTH'(900);
                bus.wdata = rand_word();
                inj_w     = 1'b1;
            end
            if (inject && k == 6 && !inj_s) begin
                bus.ld_start = 1'b1;
                inj_s        = 1'b1;
            end
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.ld_valid && bus.ld_ready === 1'b1) begin
                model[k] = w;
                k++;
            end
            tick();
            guard++;
        end
        bus.ld_valid = 1'b0;
        bus.wren     = 1'b0;
        bus.ld_start = 1'b0;
        chk_i("ld_handshakes", k, len);
        chk_b("ld_busy_throughout", busy_ok, 1'b1);
        @(negedge clk);
        chk_b("ld_done_pulse", bus.done, 1'b1);
        chk_b("ld_busy_drop", bus.busy, 1'b0);
        chk_b("ld_ready_off", bus.ld_ready, 1'b0);
        repeat (3) tick();
        chk_i("ld_done_once", done_cnt - d0, 1);
    endtask

    task automatic do_drain(input int diff, input bit bp, input int abort_at);
        int len = DEPTH >> diff;
        int n = 0, guard = 0, d0 = done_cnt, first = -1;
        bus.diff_logN = LOGE_W'(diff);
        bus.st_ready  = 1'b0;
        bus.st_start  = 1'b1;
        tick();
        bus.st_start  = 1'b0;
        for (int k = 0; k < len; k++) st_q.push_back(model[k]);
        while (n < len && guard < 8 * len + 50) begin
            bus.st_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.st_valid === 1'b1 && first < 0) first = guard;
            if (bus.st_valid === 1'b1 && bus.st_ready) n++;
            if (abort_at > 0 && n == abort_at) break;
            tick();
            guard++;
        end
        if (abort_at > 0) begin
            tick();
            bus.st_ready = 1'b0;
            rstn         = 1'b0;
            tick();
            @(negedge clk);
            chk_b("abort_busy", bus.busy, 1'b0);
            chk_b("abort_st_valid", bus.st_valid, 1'b0);
            chk_b("abort_err", bus.err, 1'b0);
            chk_b("abort_no_done", bus.done, 1'b0);
            st_q.delete();
            tick();
            rstn = 1'b1;
            repeat (4) tick();
            chk_i("abort_done_count", done_cnt - d0, 0);
        end else begin
            bus.st_ready = 1'b0;
            chk_i("st_handshakes", n, len);
            chk_b("st_first_latency", first >= RL, 1'b1);
            if (!bp) chk_b("st_full_rate", guard <= len + RL + 4, 1'b1);
            @(negedge clk);
            chk_b("st_done_pulse", bus.done, 1'b1);
            chk_b("st_busy_drop", bus.busy, 1'b0);
            chk_b("st_valid_off", bus.st_valid, 1'b0);
            repeat (3) tick();
            chk_i("st_done_once", done_cnt - d0, 1);
            chk_i("st_leftover", st_q.size(), 0);
        end
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.st_valid === 1'b1 && bus.st_ready === 1'b1) begin
                if (st_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL st_extra: got %0h with no word expected", bus.st_data);
                end else begin
                    chk_d("st_data", bus.st_data, st_q.pop_front());
                end
            end
            while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                e = rd_q.pop_front();
                chk_d("rdata", bus.rdata, e.data);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [DW-1:0] w;
        int a_r, a_w;
        bit we;
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_done", bus.done, 1'b0);
        chk_b("rst_err", bus.err, 1'b0);
        chk_b("rst_ld_ready", bus.ld_ready, 1'b0);
        chk_b("rst_st_valid", bus.st_valid, 1'b0);
        chk_d("rst_rdata", bus.rdata, '0);
        tick();
        rstn = 1'b1;
        tick();

        // Full-length fill at one word per cycle, then compute readback
        do_load(0, 1'b0, 1'b0);
        compute_read(0);
        compute_read(511);
        compute_read(1023);
        repeat (RL + 1) tick();

        // Random compute traffic on a small address window to provoke collisions
        for (int t = 0; t < 200; t++) begin
            a_r = $urandom_range(0, 15);
            a_w = $urandom_range(0, 15);
            we  = 1'($urandom_range(0, 1));
            w   = rand_word();
            bus.raddr = WIDTH'(a_r);
            bus.waddr = WIDTH'(a_w);
            bus.wren  = we;
            bus.wdata = w;
            push_rd(cyc + RL, (we && a_w == a_r) ? w : model[a_r]);
            if (we) model[a_w] = w;
            tick();
        end
        bus.wren = 1'b0;

        // Same-cycle forward on address 5, then a follow-up read of it
        w = rand_word();
        bus.raddr = WIDTH'(5);
        bus.waddr = WIDTH'(5);
        bus.wren  = 1'b1;
        bus.wdata = w;
        push_rd(cyc + RL, w);
        model[5] = w;
        tick();
        compute_read(5);
        repeat (RL + 1) tick();
        @(negedge clk);
        chk_b("err_clear_before", bus.err, 1'b0);
        tick();

        // Short fill with gaps plus protocol errors injected mid-transfer
        do_load(3, 1'b1, 1'b1);
        @(negedge clk);
        chk_b("err_set", bus.err, 1'b1);
        tick();
        compute_read(900);
        compute_read(127);
        compute_read(128);
        compute_read(1023);
        repeat (RL + 5) tick();
        @(negedge clk);
        chk_b("err_sticky", bus.err, 1'b1);
        tick();

        // Drain under random backpressure, abort one by reset, then restart
        do_drain(0, 1'b1, 0);
        do_drain(0, 1'b1, 10);
        do_drain(0, 1'b0, 0);

        repeat (RL + 2) tick();
        chk_i("rd_leftover", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
